// File: rtl/au_seq_pkg.sv
// au_seq_pkg: shared widths, Aunit mode/type enums, sequencer states and the mode-to-lane-mask helper.
package au_seq_pkg;
    localparam int ACC_WD     = 24;
    localparam int CNT_WD     = 8;
    localparam int DWD        = 8;
    localparam int AU_OD_WD   = 16;
    localparam int AU_MASK_WD = 3 * DWD;

    typedef enum logic [1:0] {XNOR, M1, M2, M4} au_sel_e;
    typedef enum logic {UNSIGNED, SIGNED} num_t_e;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} au_seq_st_e;

    function automatic logic [AU_MASK_WD-1:0] mask_of(input au_sel_e m);
        logic [AU_MASK_WD-1:0] lane;
        lane = AU_MASK_WD'({DWD{1'b1}});
        return (m == M4) ? lane << (2 * DWD) : (m == M2) ? lane << DWD : lane;
    endfunction
endpackage

// File: rtl/au_sat_acc.sv
// au_sat_acc: next value of a signed saturating accumulator; once saturated it holds the limit.
module au_sat_acc #(
    parameter int AccWd  = 24,
    parameter int AuODWd = 16
) (
    input  logic [AccWd-1:0]  i_acc,
    input  logic              i_sat,
    input  logic [AuODWd-1:0] i_sum,
    input  logic              i_zero,
    output logic [AccWd-1:0]  o_acc,
    output logic              o_sat
);
    localparam int XW = ((AccWd > AuODWd) ? AccWd : AuODWd) + 1;

    logic [XW-1:0]       s;
    logic [XW-AccWd:0]   top;
    logic                ovf;
    logic [AccWd-1:0]    lim;

    always_comb begin
        s     = {{(XW-AccWd){i_acc[AccWd-1]}}, i_acc} + {{(XW-AuODWd){i_sum[AuODWd-1]}}, i_sum};
        // bits above the result sign must all equal it, otherwise the true sum is out of range
        top   = s[XW-1:AccWd-1];
        ovf   = !(&top || !(|top));
        lim   = s[XW-1] ? {1'b1, {(AccWd-1){1'b0}}} : {1'b0, {(AccWd-1){1'b1}}};
        o_sat = i_sat | (ovf & !i_zero);
        o_acc = (i_sat || i_zero) ? i_acc : ovf ? lim : s[AccWd-1:0];
    end
endmodule

// File: rtl/au_seq.sv
// au_seq: job sequencer for one Aunit; gates LEN pixel pairs in, accumulates LEN partial sums,
// and hands the saturated result downstream.
module au_seq
    import au_seq_pkg::*;
#(
    parameter int AccWd = ACC_WD,
    parameter int CntWd = CNT_WD
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_cfg_rdy,
    output logic                  o_cfg_ack,
    input  au_sel_e               i_cfg_mode,
    input  num_t_e                i_cfg_iNumT,
    input  num_t_e                i_cfg_wNumT,
    input  logic [CntWd-1:0]      i_cfg_len,
    input  logic                  i_ipix_rdy,
    input  logic                  i_wpix_rdy,
    output logic                  o_ipix_ack,
    output logic                  o_wpix_ack,
    output logic                  o_au_ipix_rdy,
    output logic                  o_au_wpix_rdy,
    input  logic                  i_au_ipix_ack,
    input  logic                  i_au_wpix_ack,
    output logic [AU_MASK_WD-1:0] o_au_mask,
    output au_sel_e               o_au_mode,
    output num_t_e                o_au_iNumT,
    output num_t_e                o_au_wNumT,
    output logic                  o_au_reset,
    output logic                  o_au_stall,
    input  logic [AU_OD_WD-1:0]   i_au_sum,
    input  logic                  i_au_sum_rdy,
    input  logic                  i_au_sum_zero,
    output logic                  o_au_sum_ack,
    output logic [AccWd-1:0]      o_acc,
    output logic                  o_acc_rdy,
    input  logic                  i_acc_ack,
    output logic                  o_busy
);
    au_seq_st_e       state_q, state_d;
    au_sel_e          mode_q, mode_d;
    num_t_e           inum_q, inum_d, wnum_q, wnum_d;
    logic [CntWd-1:0] len_q, len_d, issue_q, issue_d, recv_q, recv_d;
    logic [AccWd-1:0] acc_q, acc_d, acc_nx;
    logic             sat_q, sat_d, sat_nx;
    logic             run, cfg_hs, issue_hs, sum_hs;

    au_sat_acc #(.AccWd(AccWd), .AuODWd(AU_OD_WD)) u_sat_acc (
        .i_acc (acc_q),
        .i_sat (sat_q),
        .i_sum (i_au_sum),
        .i_zero(i_au_sum_zero),
        .o_acc (acc_nx),
        .o_sat (sat_nx)
    );

    assign run           = state_q == RUN;
    assign cfg_hs        = i_en && state_q == IDLE && i_cfg_rdy;
    assign issue_hs      = i_en && run && i_au_ipix_ack && i_au_wpix_ack;
    assign sum_hs        = i_en && run && i_au_sum_rdy && recv_q < len_q;
    assign o_cfg_ack     = cfg_hs;
    assign o_ipix_ack    = i_en && run && i_au_ipix_ack;
    assign o_wpix_ack    = i_en && run && i_au_wpix_ack;
    assign o_au_ipix_rdy = run && issue_q < len_q && i_ipix_rdy;
    assign o_au_wpix_rdy = run && issue_q < len_q && i_wpix_rdy;
    assign o_au_sum_ack  = sum_hs;
    assign o_au_mask     = (run || state_q == LOAD) ? mask_of(mode_q) : '0;
    assign o_au_mode     = mode_q;
    assign o_au_iNumT    = inum_q;
    assign o_au_wNumT    = wnum_q;
    assign o_au_reset    = state_q == LOAD;
    assign o_au_stall    = i_en;
    assign o_acc         = acc_q;
    assign o_acc_rdy     = state_q == OUT;
    assign o_busy        = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        inum_d  = inum_q;
        wnum_d  = wnum_q;
        len_d   = len_q;
        issue_d = issue_q + CntWd'(issue_hs);
        recv_d  = recv_q + CntWd'(sum_hs);
        acc_d   = sum_hs ? acc_nx : acc_q;
        sat_d   = sum_hs ? sat_nx : sat_q;
        if (cfg_hs) begin
            mode_d  = i_cfg_mode;
            inum_d  = i_cfg_iNumT;
            wnum_d  = i_cfg_wNumT;
            len_d   = i_cfg_len;
            issue_d = '0;
            recv_d  = '0;
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = (i_cfg_len == '0) ? OUT : LOAD;
        end
        if (state_q == LOAD) state_d = RUN;
        if (sum_hs && recv_q == len_q - CntWd'(1)) state_d = OUT;
        if (state_q == OUT && i_acc_ack) state_d = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            mode_q  <= XNOR;
            inum_q  <= UNSIGNED;
            wnum_q  <= UNSIGNED;
            len_q   <= '0;
            issue_q <= '0;
            recv_q  <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else if (i_en) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            inum_q  <= inum_d;
            wnum_q  <= wnum_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end
endmodule

// File: tb/tb_au_seq.sv
// tb_au_seq: directed jobs on a 24-bit and an 8-bit accumulator instance driven by the same stimulus.
module tb_au_seq;
    import au_seq_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic en = 1'b1, cfg_rdy = 1'b0, ipix_rdy = 1'b0, wpix_rdy = 1'b0;
    logic au_iack = 1'b0, au_wack = 1'b0, sum_rdy = 1'b0, sum_zero = 1'b0, acc_ack = 1'b0;
    au_sel_e mode = XNOR;
    num_t_e inum = UNSIGNED, wnum = UNSIGNED;
    logic [7:0] len = '0;
    logic [15:0] sum = '0;

    logic cfg_ack, ipix_ack, wpix_ack, au_irdy, au_wrdy, au_reset, au_stall, sum_ack, acc_rdy, busy;
    logic [23:0] au_mask, acc;
    au_sel_e au_mode;
    num_t_e au_inum, au_wnum;

    logic cfg_ack8, ipix_ack8, wpix_ack8, au_irdy8, au_wrdy8, au_reset8, au_stall8, sum_ack8, acc_rdy8, busy8;
    logic [23:0] au_mask8;
    logic [7:0] acc8;
    au_sel_e au_mode8;
    num_t_e au_inum8, au_wnum8;

    au_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_rdy(cfg_rdy), .o_cfg_ack(cfg_ack),
        .i_cfg_mode(mode), .i_cfg_iNumT(inum), .i_cfg_wNumT(wnum), .i_cfg_len(len),
        .i_ipix_rdy(ipix_rdy), .i_wpix_rdy(wpix_rdy), .o_ipix_ack(ipix_ack), .o_wpix_ack(wpix_ack),
        .o_au_ipix_rdy(au_irdy), .o_au_wpix_rdy(au_wrdy), .i_au_ipix_ack(au_iack), .i_au_wpix_ack(au_wack),
        .o_au_mask(au_mask), .o_au_mode(au_mode), .o_au_iNumT(au_inum), .o_au_wNumT(au_wnum),
        .o_au_reset(au_reset), .o_au_stall(au_stall), .i_au_sum(sum), .i_au_sum_rdy(sum_rdy),
        .i_au_sum_zero(sum_zero), .o_au_sum_ack(sum_ack), .o_acc(acc), .o_acc_rdy(acc_rdy),
        .i_acc_ack(acc_ack), .o_busy(busy)
    );

    au_seq #(.AccWd(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_rdy(cfg_rdy), .o_cfg_ack(cfg_ack8),
        .i_cfg_mode(mode), .i_cfg_iNumT(inum), .i_cfg_wNumT(wnum), .i_cfg_len(len),
        .i_ipix_rdy(ipix_rdy), .i_wpix_rdy(wpix_rdy), .o_ipix_ack(ipix_ack8), .o_wpix_ack(wpix_ack8),
        .o_au_ipix_rdy(au_irdy8), .o_au_wpix_rdy(au_wrdy8), .i_au_ipix_ack(au_iack), .i_au_wpix_ack(au_wack),
        .o_au_mask(au_mask8), .o_au_mode(au_mode8), .o_au_iNumT(au_inum8), .o_au_wNumT(au_wnum8),
        .o_au_reset(au_reset8), .o_au_stall(au_stall8), .i_au_sum(sum), .i_au_sum_rdy(sum_rdy),
        .i_au_sum_zero(sum_zero), .o_au_sum_ack(sum_ack8), .o_acc(acc8), .o_acc_rdy(acc_rdy8),
        .i_acc_ack(acc_ack), .o_busy(busy8)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string tag, input au_sel_e m, input int n, input int s0, input int s1,
                           input int s2, input int s3, input logic [3:0] z, input logic [23:0] emask,
                           input int stop_k, input int e24, input int e8);
        int s[4];
        int k = 0, pix = 0, rst_cnt = 0, cyc = 0;
        s = '{s0, s1, s2, s3};
        cfg_rdy = 1'b1; mode = m; len = 8'(n); inum = SIGNED; wnum = UNSIGNED;
        #1 chk({tag, "_cfg_ack"}, 32'(cfg_ack), 1);
        tick();
        cfg_rdy = 1'b0;
        while (!acc_rdy && cyc < 60) begin
            if (k == stop_k) return;
            ipix_rdy = 1'b1; wpix_rdy = 1'b1;
            sum_rdy = k < n;
            sum = (k < n) ? 16'(s[k]) : '0;
            sum_zero = (k < n) ? z[k] : 1'b0;
            #1;
            au_iack = au_irdy; au_wack = au_wrdy;
            #1;
            if (cyc == 0) chk({tag, "_load_mask"}, 32'(au_mask), 32'(emask));
            pix += int'(ipix_ack);
            rst_cnt += int'(au_reset);
            if (sum_ack) k++;
            tick();
            cyc++;
        end
        ipix_rdy = 1'b0; wpix_rdy = 1'b0; au_iack = 1'b0; au_wack = 1'b0; sum_rdy = 1'b0; sum_zero = 1'b0;
        #1;
        chk({tag, "_acc_rdy"}, 32'(acc_rdy), 1);
        chk({tag, "_acc"}, int'($signed(acc)), e24);
        chk({tag, "_acc8"}, int'($signed(acc8)), e8);
        chk({tag, "_pix_acks"}, pix, n);
        chk({tag, "_sum_acks"}, k, n);
        chk({tag, "_au_reset_pulses"}, rst_cnt, 1);
        chk({tag, "_inumt"}, 32'(au_inum), 32'(SIGNED));
    endtask

    task automatic release_job(input string tag);
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
        #1 chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_mask", 32'(au_mask), 0);
        chk("rst_mode", 32'(au_mode), 32'(XNOR));
        chk("rst_acc_rdy", 32'(acc_rdy), 0);
        rst_n = 1'b1;
        tick();

        run_job("m2", M2, 4, 3, -6, 9, 0, 4'b1000, 24'h00FF00, -1, 6, 6);
        release_job("m2");
        run_job("xnor", XNOR, 2, -16, 16, 0, 0, 4'b0000, 24'h0000FF, -1, 0, 0);
        release_job("xnor");
        run_job("m4sat", M4, 3, 100, 100, -50, 0, 4'b0000, 24'hFF0000, -1, 150, 127);

        len = 8'd0;
        cfg_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_cfg_ack", 32'(cfg_ack), 0);
            chk("hold_acc", int'($signed(acc)), 150);
            chk("hold_acc8", int'($signed(acc8)), 127);
            tick();
        end
        acc_ack = 1'b1;
        #1 chk("ack_cfg_ack", 32'(cfg_ack), 0);
        tick();
        acc_ack = 1'b0;
        #1 chk("len0_cfg_ack", 32'(cfg_ack), 1);
        tick();
        cfg_rdy = 1'b0;
        ipix_rdy = 1'b1; wpix_rdy = 1'b1; au_iack = 1'b1; au_wack = 1'b1;
        #1;
        chk("len0_acc_rdy", 32'(acc_rdy), 1);
        chk("len0_acc", int'($signed(acc)), 0);
        chk("len0_au_reset", 32'(au_reset), 0);
        chk("len0_pix_ack", 32'(ipix_ack), 0);
        ipix_rdy = 1'b0; wpix_rdy = 1'b0; au_iack = 1'b0; au_wack = 1'b0;
        release_job("len0");

        run_job("abort", M2, 4, 5, 5, 5, 5, 4'b0000, 24'h00FF00, 2, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_acc", 32'(acc), 0);
        chk("abort_mask", 32'(au_mask), 0);
        chk("abort_mode", 32'(au_mode), 32'(XNOR));
        chk("abort_au_irdy", 32'(au_irdy), 0);
        chk("abort_sum_ack", 32'(sum_ack), 0);
        ipix_rdy = 1'b0; wpix_rdy = 1'b0; au_iack = 1'b0; au_wack = 1'b0; sum_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_job("after", XNOR, 2, 7, 8, 0, 0, 4'b0000, 24'h0000FF, -1, 15, 15);
        release_job("after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
